// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and mode encodings for the Gray codec pipeline.
package gray_pkg;

  localparam logic        MODE_G2B = 1'b0;
  localparam logic        MODE_B2G = 1'b1;
  localparam int unsigned MAX_W    = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned POP_W    = 6;

  // Mask selecting the low w bits of a MAX_W-bit word.
  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      m[i] = (i < w);
    end
    return m;
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                input int unsigned w);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    logic             acc;
    gm  = g & width_mask(w);
    b   = '0;
    acc = 1'b0;
    for (int i = int'(MAX_W) - 1; i >= 0; i--) begin
      acc  = acc ^ gm[i];
      b[i] = acc;
    end
    return b;
  endfunction

  // Binary to Gray: word XOR its logical right shift.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                input int unsigned w);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Number of set bits among the low w bits.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] x,
                                                input int unsigned w);
    logic [MAX_W-1:0] xm;
    logic [POP_W-1:0] n;
    xm = x & width_mask(w);
    n  = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      n = n + POP_W'(xm[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_adj_check.sv
// Gray adjacency checker: compares each accepted Gray word with the previous one
// and keeps a saturating count of words that changed more than one bit.
module gray_adj_check
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  input  logic             err_clr,
  output logic             err_c,
  output logic [CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] ref_q, ref_d;
  logic             ref_valid_q, ref_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POP_W-1:0] diff_c;

  assign err_count = cnt_q;

  // Error flag for the current input word plus reference/counter next state.
  always_comb begin
    ref_d       = ref_q;
    ref_valid_d = ref_valid_q;
    cnt_d       = cnt_q;
    err_c       = 1'b0;
    diff_c      = popcount(MAX_W'(data ^ ref_q), WIDTH);

    if ((mode == MODE_G2B) && ref_valid_q && (diff_c > POP_W'(1))) begin
      err_c = 1'b1;
    end

    if (accept) begin
      if (mode == MODE_G2B) begin
        ref_d       = data;
        ref_valid_d = 1'b1;
      end else begin
        ref_valid_d = 1'b0;
      end
      if (err_c && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Clear wins over a same-cycle increment.
    if (err_clr) begin
      cnt_d = '0;
    end
  end

  // Reference word, its valid flag and the error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready pipeline converting Gray<->binary per word, with an
// optional adjacency checker whose flag travels alongside each word.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHECK_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_err,
  input  logic             err_clr,
  output logic [15:0]      err_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s1_mode_q, s1_mode_d;
  logic             s1_err_q, s1_err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_mode_q, out_mode_d;
  logic             out_err_q, out_err_d;
  logic [WIDTH-1:0] conv_c;
  logic             err_c;
  logic             accept_c;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept_c  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign out_err   = out_err_q;

  if (CHECK_EN != 0) begin : g_check
    gray_adj_check #(.WIDTH(WIDTH)) u_check (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept_c),
      .mode      (in_mode),
      .data      (in_data),
      .err_clr   (err_clr),
      .err_c     (err_c),
      .err_count (err_count)
    );
  end else begin : g_no_check
    assign err_c     = 1'b0;
    assign err_count = '0;
  end

  // Conversion of the incoming word in the selected direction.
  always_comb begin
    conv_c = '0;
    if (in_mode == MODE_G2B) begin
      conv_c = WIDTH'(gray2bin(MAX_W'(in_data), WIDTH));
    end else begin
      conv_c = WIDTH'(bin2gray(MAX_W'(in_data), WIDTH));
    end
  end

  // Stage advance: S1 into the output register, input into S1.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_mode_d   = s1_mode_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    if (in_ready) begin
      out_valid_d = s1_valid_q;
      out_data_d  = s1_data_q;
      out_mode_d  = s1_mode_q;
      out_err_d   = s1_err_q;
      s1_valid_d  = in_valid;
      s1_data_d   = conv_c;
      s1_mode_d   = in_mode;
      s1_err_d    = err_c && in_valid;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule
